// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port integer register file.
package regfile_pkg;

    localparam int DEF_AW = 5;

    typedef logic [DEF_AW-1:0] reg_addr_t;

    typedef enum logic {
        RF_INIT,
        RF_READY
    } rf_state_e;

    localparam reg_addr_t   REG_ZERO        = '0;
    localparam logic [31:0] DEFAULT_SP_INIT = 32'h1fff;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS = 32,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              set_i,
    input  logic [AW-1:0]     set_idx_i,
    input  logic              clr_i,
    input  logic [AW-1:0]     clr_idx_i,
    input  logic [NRD*AW-1:0] look_addr_i,
    output logic [NRD-1:0]    pend_o
);

    logic [NREGS-1:0]       pend_q;
    logic [NREGS-1:0]       pend_d;
    logic [NRD-1:0][AW-1:0] look;

    assign look = look_addr_i;

    // Set is applied after clear so the newer producer wins on a collision.
    always_comb begin
        pend_d = pend_q;
        if (en_i) begin
            if (clr_i && clr_idx_i != AW'(REG_ZERO)) begin
                pend_d[clr_idx_i] = 1'b0;
            end
            if (set_i && set_idx_i != AW'(REG_ZERO)) begin
                pend_d[set_idx_i] = 1'b1;
            end
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        pend_o = '0;
        for (int i = 0; i < NRD; i++) begin
            pend_o[i] = pend_q[look[i]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// N-read/1-write register file with post-reset clear sequencer and hazard scoreboard.
// Define REGFILE_BYPASS_EN to forward the in-flight write to matching read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int               XLEN    = 32,
    parameter  int               NREGS   = 32,
    parameter  int               NRD     = 2,
    parameter  int               SP_IDX  = 2,
    parameter  logic [XLEN-1:0]  SP_INIT = XLEN'(DEFAULT_SP_INIT),
    localparam int               AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rs_pending,
    input  logic                we,
    input  logic [AW-1:0]       rd,
    input  logic [XLEN-1:0]     wdata,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic                init_busy
);

    rf_state_e               state_q;
    rf_state_e               state_d;
    logic [AW-1:0]           clr_idx_q;
    logic [AW-1:0]           clr_idx_d;
    logic [XLEN-1:0]         regs_q [NREGS];
    logic                    ready;
    logic                    wr_en;
    logic [NRD-1:0]          sb_pend;
    logic [NRD-1:0][AW-1:0]  ra;
    logic [NRD-1:0][XLEN-1:0] rd_mux;
    logic [NRD-1:0]          pend_mux;

    assign ready     = (state_q == RF_READY);
    assign init_busy = !ready;
    assign wr_en     = ready && we && (rd != AW'(REG_ZERO));
    assign ra        = rs_addr;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            RF_INIT: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == AW'(NREGS - 1)) begin
                    state_d = RF_READY;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RF_INIT;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Array has no reset; the clear walk is what initialises it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (!ready) begin
                regs_q[clr_idx_q] <= (clr_idx_q == AW'(SP_IDX)) ? SP_INIT : '0;
            end else if (wr_en) begin
                regs_q[rd] <= wdata;
            end
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .en_i        (ready),
        .set_i       (issue_valid),
        .set_idx_i   (issue_rd),
        .clr_i       (we),
        .clr_idx_i   (rd),
        .look_addr_i (rs_addr),
        .pend_o      (sb_pend)
    );

    always_comb begin
        rd_mux   = '0;
        pend_mux = '0;
        for (int i = 0; i < NRD; i++) begin
            if (ready && ra[i] != AW'(REG_ZERO)) begin
                rd_mux[i]   = regs_q[ra[i]];
                pend_mux[i] = sb_pend[i];
`ifdef REGFILE_BYPASS_EN
                if (wr_en && rd == ra[i]) begin
                    rd_mux[i]   = wdata;
                    pend_mux[i] = 1'b0;
                end
`endif
            end
        end
    end

    assign rdata      = rd_mux;
    assign rs_pending = pend_mux;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes expectations, a monitor checks them.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NRD*AW-1:0]   rs_addr = '0;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rs_pending;
    logic                we = 1'b0;
    logic [AW-1:0]       rd = '0;
    logic [XLEN-1:0]     wdata = '0;
    logic                issue_valid = 1'b0;
    logic [AW-1:0]       issue_rd = '0;
    logic                init_busy;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk         (clk),
        .reset       (reset),
        .rs_addr     (rs_addr),
        .rdata       (rdata),
        .rs_pending  (rs_pending),
        .we          (we),
        .rd          (rd),
        .wdata       (wdata),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .init_busy   (init_busy)
    );

    typedef struct {
        logic                busy;
        logic [NRD*XLEN-1:0] data;
        logic [NRD-1:0]      pend;
        int                  phase;
        int                  cyc;
    } exp_t;

    exp_t q[$];

    // Behavioural model of architectural state
    logic [XLEN-1:0] mregs [NREGS];
    bit              mpend [NREGS];
    int              busy_left = 0;
    bit              known = 0;
    int              phase = 0;
    int              cyc = 0;
    int              vectors = 0;
    int              errors = 0;
    bit              bypass;

    initial begin
`ifdef REGFILE_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
    end

    task automatic step(input bit rst, input bit w, input int r,
                        input logic [31:0] wd, input bit iv, input int ir,
                        input int a0, input int a1);
        exp_t e;
        int   a;
        int   idx;
        reset       = rst;
        we          = w;
        rd          = r[AW-1:0];
        wdata       = wd;
        issue_valid = iv;
        issue_rd    = ir[AW-1:0];
        rs_addr     = {a1[AW-1:0], a0[AW-1:0]};
        cyc++;
        if (known) begin
            e.busy  = (busy_left > 0);
            e.data  = '0;
            e.pend  = '0;
            e.phase = phase;
            e.cyc   = cyc;
            for (int i = 0; i < NRD; i++) begin
                a = (i == 0) ? a0 : a1;
                if (busy_left == 0 && a != 0) begin
                    if (bypass && w && r != 0 && r == a) begin
                        e.data[i*XLEN +: XLEN] = wd;
                        e.pend[i] = 1'b0;
                    end else begin
                        e.data[i*XLEN +: XLEN] = mregs[a];
                        e.pend[i] = mpend[a];
                    end
                end
            end
            q.push_back(e);
        end
        if (rst) begin
            known     = 1;
            busy_left = NREGS;
            for (int k = 0; k < NREGS; k++) mpend[k] = 0;
        end else if (busy_left > 0) begin
            idx        = NREGS - busy_left;
            mregs[idx] = (idx == 2) ? 32'h1fff : 32'h0;
            busy_left--;
        end else begin
            if (w && r != 0) begin
                mregs[r] = wd;
                mpend[r] = 0;
            end
            if (iv && ir != 0) mpend[ir] = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input int a0, input int a1);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, a0, a1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if (init_busy !== e.busy || rdata !== e.data || rs_pending !== e.pend) begin
                errors++;
                $display("FAIL chk ph%0d cyc%0d: busy got %b want %b, rdata got %h want %h, pend got %b want %b",
                         e.phase, e.cyc, init_busy, e.busy, rdata, e.data, rs_pending, e.pend);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        phase = 1;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(NREGS, 2, 0);
        for (int k = 0; k < NREGS / 2; k++) idle(1, 2 * k, 2 * k + 1);

        phase = 2;
        step(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 2);
        idle(1, 5, 0);

        phase = 3;
        step(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 5);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        idle(1, 0, 0);

        phase = 4;
        step(0, 0, 0, 0, 1, 7, 7, 7);
        step(0, 1, 7, 32'h0000_0777, 1, 7, 7, 0);
        step(0, 1, 7, 32'h0000_0778, 0, 0, 7, 0);
        idle(2, 7, 0);

        phase = 5;
        step(0, 1, 9, 32'h0000_1234, 0, 0, 9, 0);
        idle(1, 9, 0);
        step(1, 0, 0, 0, 0, 0, 9, 0);
        idle(10, 9, 0);
        step(1, 0, 0, 0, 0, 0, 9, 0);
        idle(NREGS, 9, 2);
        idle(1, 9, 2);

        phase = 6;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < NREGS; k++) step(0, 1, 3, 32'hA5A5_0003, 1, 3, 3, 0);
        idle(1, 3, 4);

        phase = 7;
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 149) == 0),
                 $urandom_range(0, 1),
                 $urandom_range(0, 7),
                 $urandom,
                 $urandom_range(0, 1),
                 $urandom_range(0, 7),
                 (k % 4 == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7),
                 $urandom_range(0, 7));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
